// File: rtl/ring_pkg.sv
// rtl/ring_pkg.sv - shared packet types and widths for the ring stop arbiter
// Purpose: packet type encodings, ring field widths, packet struct and
//          client FSM state type shared by ring_port_arbiter.
// Ports:   none (package).
package ring_pkg;

   localparam int ADDR_W = 36;
   localparam int DATA_W = 512;
   localparam int ID_W   = 5;

   typedef enum logic [2:0] {
      PKT_EMPTY   = 3'b000,
      PKT_WR_REQ  = 3'b001,
      PKT_RD_REQ  = 3'b011,
      PKT_WR_ACK  = 3'b101,
      PKT_RD_RESP = 3'b110
   } pkt_type_t;

   typedef struct packed {
      pkt_type_t         ptype;
      logic [ID_W-1:0]   id;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } ring_pkt_t;

   typedef enum logic [1:0] {
      CL_IDLE      = 2'd0,
      CL_WAIT_SLOT = 2'd1,
      CL_WAIT_RESP = 2'd2
   } cl_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot arbiter with grant-qualified pointer
// Purpose: picks one requester starting from the priority pointer; the
//          pointer moves past the winner only when grant_en_i confirms the grant.
// Ports:   clk, rst        - clock, synchronous active-high reset
//          req_i[N]        - request vector
//          grant_en_i      - the grant is actually taken this cycle
//          grant_o[N]      - one-hot winner (combinational)
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req_i,
   input  logic         grant_en_i,
   output logic [N-1:0] grant_o
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] idx;
   logic          found;

   always_comb begin
      grant_o = '0;
      ptr_d   = ptr_q;
      found   = 1'b0;
      idx     = '0;
      for (int off = 0; off < N; off++) begin
         idx = PW'((int'(ptr_q) + off) % N);
         if (!found && req_i[idx]) begin
            found        = 1'b1;
            grant_o[idx] = 1'b1;
            ptr_d        = PW'((int'(idx) + 1) % N);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (grant_en_i && found) begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/ring_port_arbiter.sv
// rtl/ring_port_arbiter.sv - shares one ring stop between local requesters
// Purpose: injects client read/write requests into empty (or just-consumed)
//          ring slots round-robin, removes responses addressed to this stop,
//          returns them to the owning client and times out lost responses.
// Ports:   clk, rst                  - clock, synchronous active-high reset
//          cl_req_*_i / cl_req_ready_o - per-client request handshake
//          cl_resp_*_o               - per-client response / timeout pulses
//          slot_*_i                  - packet currently passing this stop
//          overwrite_o, ovr_*_o      - replacement packet, sampled by the ring
module ring_port_arbiter
   import ring_pkg::*;
#(
   parameter logic [3:0] NODE_ID     = 4'd0,
   parameter int         NUM_CLIENTS = 2,
   parameter int         TIMEOUT     = 1024,
   parameter int         TO_W        = 11
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_CLIENTS-1:0]             cl_req_valid_i,
   output logic [NUM_CLIENTS-1:0]             cl_req_ready_o,
   input  logic [NUM_CLIENTS-1:0]             cl_req_write_i,
   input  logic [NUM_CLIENTS-1:0][ADDR_W-1:0] cl_req_addr_i,
   input  logic [NUM_CLIENTS-1:0][DATA_W-1:0] cl_req_data_i,
   output logic [NUM_CLIENTS-1:0]             cl_resp_valid_o,
   output logic [NUM_CLIENTS-1:0]             cl_resp_write_o,
   output logic [DATA_W-1:0]                  cl_resp_data_o,
   output logic [NUM_CLIENTS-1:0]             cl_resp_err_o,
   input  logic [2:0]                         slot_type_i,
   input  logic [ID_W-1:0]                    slot_id_i,
   input  logic [ADDR_W-1:0]                  slot_addr_i,
   input  logic [DATA_W-1:0]                  slot_data_i,
   output logic                               overwrite_o,
   output logic [2:0]                         ovr_type_o,
   output logic [ID_W-1:0]                    ovr_id_o,
   output logic [ADDR_W-1:0]                  ovr_addr_o,
   output logic [DATA_W-1:0]                  ovr_data_o
);

   logic                              is_resp;
   logic                              consume;
   logic                              slot_free;
   logic                              grant_en;
   logic                              ours_rd;
   logic [NUM_CLIENTS-1:0]            owner_sel;
   logic [NUM_CLIENTS-1:0]            ours_vec;
   logic [NUM_CLIENTS-1:0]            waiting_slot;
   logic [NUM_CLIENTS-1:0]            grant;
   logic [NUM_CLIENTS-1:0]            lat_wr;
   logic [NUM_CLIENTS-1:0][ADDR_W-1:0] lat_addr;
   logic [NUM_CLIENTS-1:0][DATA_W-1:0] lat_data;
   logic [DATA_W-1:0]                 resp_data_q;
   ring_pkt_t                         ovr;
   logic                              unused_slot_addr;

   // The ring never needs the address of a returning response.
   assign unused_slot_addr = ^slot_addr_i;

   // Every response carrying our node id leaves the ring here, whether a
   // client still wants it or not, so such a slot is always reusable.
   assign is_resp   = (slot_type_i == PKT_WR_ACK) || (slot_type_i == PKT_RD_RESP);
   assign consume   = is_resp && (slot_id_i[3:0] == NODE_ID);
   assign slot_free = (slot_type_i == PKT_EMPTY) || consume;
   assign grant_en  = slot_free && !rst;
   assign ours_rd   = (|ours_vec) && (slot_type_i == PKT_RD_RESP);

   rr_arbiter #(
      .N (NUM_CLIENTS)
   ) u_rr (
      .clk        (clk),
      .rst        (rst),
      .req_i      (waiting_slot),
      .grant_en_i (grant_en),
      .grant_o    (grant)
   );

   for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_client
      cl_state_t         state_q;
      logic              wr_q;
      logic [ADDR_W-1:0] addr_q;
      logic [DATA_W-1:0] data_q;
      logic [TO_W-1:0]   timer_q;
      logic              resp_valid_q;
      logic              resp_write_q;
      logic              err_q;

      assign owner_sel[i]    = (slot_id_i[ID_W-1] == 1'(i));
      assign ours_vec[i]     = consume && owner_sel[i] && (state_q == CL_WAIT_RESP);
      assign waiting_slot[i] = (state_q == CL_WAIT_SLOT);
      assign lat_wr[i]       = wr_q;
      assign lat_addr[i]     = addr_q;
      assign lat_data[i]     = data_q;

      assign cl_req_ready_o[i]  = (state_q == CL_IDLE);
      assign cl_resp_valid_o[i] = resp_valid_q;
      assign cl_resp_write_o[i] = resp_write_q;
      assign cl_resp_err_o[i]   = err_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            state_q      <= CL_IDLE;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            timer_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_write_q <= 1'b0;
            err_q        <= 1'b0;
         end else begin
            resp_valid_q <= 1'b0;
            resp_write_q <= 1'b0;
            err_q        <= 1'b0;
            case (state_q)
               CL_IDLE: begin
                  if (cl_req_valid_i[i]) begin
                     state_q <= CL_WAIT_SLOT;
                     wr_q    <= cl_req_write_i[i];
                     addr_q  <= cl_req_addr_i[i];
                     data_q  <= cl_req_data_i[i];
                  end
               end
               CL_WAIT_SLOT: begin
                  if (grant_en && grant[i]) begin
                     state_q <= CL_WAIT_RESP;
                     timer_q <= '0;
                  end
               end
               CL_WAIT_RESP: begin
                  // A response arriving on the final count beats the timeout.
                  if (ours_vec[i]) begin
                     state_q      <= CL_IDLE;
                     resp_valid_q <= 1'b1;
                     resp_write_q <= (slot_type_i == PKT_WR_ACK);
                  end else if (timer_q == TO_W'(TIMEOUT - 1)) begin
                     state_q <= CL_IDLE;
                     err_q   <= 1'b1;
                     timer_q <= TO_W'(TIMEOUT);
                  end else begin
                     timer_q <= timer_q + 1'b1;
                  end
               end
               default: state_q <= CL_IDLE;
            endcase
         end
      end
   end

   // Read data is shared by all clients; only the pulsing client looks at it.
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_data_q <= '0;
      end else begin
         resp_data_q <= ours_rd ? slot_data_i : '0;
      end
   end

   assign cl_resp_data_o = resp_data_q;

   // An injecting client takes priority over the EMPTY that a consume would
   // otherwise leave behind, so remove-and-inject happens in one slot pass.
   always_comb begin
      ovr         = '0;
      ovr.ptype   = PKT_EMPTY;
      overwrite_o = 1'b0;
      if (!rst) begin
         overwrite_o = consume;
         for (int c = 0; c < NUM_CLIENTS; c++) begin
            if (grant_en && grant[c]) begin
               overwrite_o = 1'b1;
               ovr.ptype   = lat_wr[c] ? PKT_WR_REQ : PKT_RD_REQ;
               ovr.id      = {c[0], NODE_ID};
               ovr.addr    = lat_addr[c];
               ovr.data    = lat_data[c];
            end
         end
      end
   end

   assign ovr_type_o = ovr.ptype;
   assign ovr_id_o   = ovr.id;
   assign ovr_addr_o = ovr.addr;
   assign ovr_data_o = ovr.data;

endmodule

// File: doc/ring_port_arbiter.md
Name: ring_port_arbiter

Overview:
- Shares one circular_memory_unit ring stop between NUM_CLIENTS local requesters, e.g. a core's icache and dcache.
- Each client has at most one transaction outstanding.
- When the slot passing the stop is empty, the block injects the client's read or write request, choosing clients round-robin.
- It removes response packets addressed to this stop, returns them to the owning client, and runs a per-client response watchdog.

Parameters:
- NODE_ID, 4'd0: ring stop id, carried in packet id[3:0].
- NUM_CLIENTS, 2: number of requesters. Legal values are 1 or 2; id[4] carries the client index.
- TIMEOUT, 1024: cycles a client waits for a response before it is flagged as an error.
- TO_W, 11: timeout counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- cl_req_valid  in  NUM_CLIENTS  client request valid
- cl_req_ready  out  NUM_CLIENTS  client idle; a request is accepted when valid&ready
- cl_req_write  in  NUM_CLIENTS  1=write, 0=read
- cl_req_addr  in  NUM_CLIENTS x 36  request address
- cl_req_data  in  NUM_CLIENTS x 512  write data
- cl_resp_valid  out  NUM_CLIENTS  one-cycle response pulse
- cl_resp_write  out  NUM_CLIENTS  response was a write ack
- cl_resp_data  out  512  read data for the pulsing client
- cl_resp_err  out  NUM_CLIENTS  one-cycle timeout pulse
- slot_type  in  3  current slot packet type (circ unit packet_type_req_out)
- slot_id  in  5  current slot id
- slot_addr  in  36  current slot address
- slot_data  in  512  current slot data
- overwrite  out  1  replace the slot contents this cycle
- ovr_type  out  3  replacement packet type
- ovr_id  out  5  replacement id
- ovr_addr  out  36  replacement address
- ovr_data  out  512  replacement data

Behaviour:
- Packet types: EMPTY=000, WR_REQ=001, RD_REQ=011, WR_ACK=101, RD_RESP=110. The memory controller echoes the full 5-bit id.
- Per-client FSM with states IDLE, WAIT_SLOT and WAIT_RESP.
  - cl_req_ready = (state==IDLE).
  - On accept, latch write/addr/data and go to WAIT_SLOT on the next cycle.
  - A client is granted when the slot is "free": slot_type==EMPTY, or the slot holds a response being consumed this cycle.
  - On grant: overwrite=1, ovr_type = WR_REQ or RD_REQ, ovr_id={client_idx,NODE_ID}, ovr_addr/ovr_data from the latch. The client then goes to WAIT_RESP and its timer clears.
- Ownership test: a slot is "ours" when slot_type is WR_ACK or RD_RESP, slot_id[3:0]==NODE_ID, and client slot_id[4] is in WAIT_RESP.
- Consume: when a slot is ours, overwrite=1.
  - If no client is injecting that cycle, ovr_type=EMPTY and ovr_id/ovr_addr/ovr_data=0.
  - If a client is injecting, the request replaces the response directly in the same cycle.
- Response delivery:
  - The next cycle, cl_resp_valid pulses for that client.
  - cl_resp_write=(type==WR_ACK).
  - cl_resp_data is the registered slot_data; it is 0 for write acks.
  - The client returns to IDLE; it can accept a new request that same pulse cycle.
- Stale responses: a response with a matching NODE_ID whose client is not in WAIT_RESP is consumed and discarded (overwrite to EMPTY), with no pulse.
- Foreign packets, and our own requests still circulating, are never overwritten.
- Arbitration:
  - With several clients in WAIT_SLOT on a free slot, grant one using round-robin.
  - The pointer advances past the winner only on a grant.
  - After reset, client 0 has priority.
  - At most one injection per cycle.
- Watchdog:
  - The counter increments each cycle in WAIT_RESP and saturates.
  - When it reaches TIMEOUT, pulse cl_resp_err and go to IDLE.
  - If a valid response arrives on the same cycle the count reaches TIMEOUT, the response wins and no error is raised.
- overwrite and ovr_* are combinational from slot_* and registered state. This is zero-cycle, because the circ unit samples them at the clock edge.
- Latency: a request accepted at cycle t injects at t+1 at the earliest.
- Reset (synchronous, active-high; may occur at any time, including mid-transaction):
  - All FSMs go to IDLE, timers to 0, the round-robin pointer to 0.
  - cl_req_ready is all-ones the cycle after reset.
  - cl_resp_valid, cl_resp_err, cl_resp_write and cl_resp_data are 0.
  - overwrite is 0 while rst is high.
  - Requests in flight are abandoned; their later responses are discarded as stale.

Decomposition:
- Shared package ring_pkg holds:
  - pkt_type_t (enum above);
  - widths ADDR_W=36, DATA_W=512, ID_W=5;
  - a ring_pkt_t struct (type, id, addr, data).
- Sub-module rr_arbiter (parameter N; ports req, grant_en, grant one-hot, pointer update on grant_en) holds the round-robin logic.
- Client FSMs are a generate loop inside ring_port_arbiter.

Test Plan:
- Single read: client 0 issues a read of 36'h000_0123 while the slot is EMPTY.
  - Next cycle: overwrite=1, ovr_type=011, ovr_id=5'h0_0 with NODE_ID=0.
  - Drive slot RD_RESP id 0, data 512'h123: overwrite=1, ovr_type=000, and the next cycle cl_resp_valid[0]=1 with cl_resp_data=512'h123.
- Contention: both clients are in WAIT_SLOT and an EMPTY slot arrives each cycle.
  - Client 0 is injected first, then client 1 (ovr_id=5'h10).
  - On the next contention round after both complete, client 0 is granted again because the pointer wrapped.
- Consume plus inject: client 1 is waiting for a slot while a WR_ACK for client 0 arrives.
  - The same cycle: overwrite with WR_REQ id 5'h10.
  - The next cycle: cl_resp_valid[0]=1, cl_resp_write[0]=1.
- Foreign and busy slots:
  - A slot holding RD_REQ id 5'h03 leaves overwrite=0 and the client keeps waiting.
  - An RD_RESP with id[3:0]=3 also leaves overwrite=0.
- Timeout with TIMEOUT=8 and no response:
  - cl_resp_err pulses 8 cycles after injection and cl_req_ready returns to 1.
  - A later matching response is consumed to EMPTY with no cl_resp_valid.
- Reset mid-operation: assert rst while client 0 is in WAIT_RESP.
  - All ready bits go high and overwrite is 0 during reset.
  - The returning response is discarded.
